// File: rtl/peripheral_mpram_ahb4_pkg.sv
// Shared AHB-Lite codes, pipeline slot layouts and error-sequence states
// for the per-core multi-port RAM master.
package peripheral_mpram_ahb4_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic [2:0] HSIZE_B8    = 3'd0;
    localparam logic [2:0] HSIZE_B16   = 3'd1;
    localparam logic [2:0] HSIZE_B32   = 3'd2;
    localparam logic [2:0] HSIZE_B64   = 3'd3;
    localparam logic [2:0] HSIZE_B128  = 3'd4;
    localparam logic [2:0] HSIZE_B256  = 3'd5;
    localparam logic [2:0] HSIZE_B512  = 3'd6;
    localparam logic [2:0] HSIZE_B1024 = 3'd7;

    // RUN: normal pipelining; ERR1/ERR2: second cycle of a slave ERROR and
    // the cycle that flushes the cancelled address-phase entry.
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } fsm_state_t;

    // Address-phase slot control (addr/wdata live beside it, sized by XLEN/PLEN).
    typedef struct packed {
        logic       valid;
        logic       write;
        logic [2:0] size;
        logic       lerr;
    } a_slot_t;

    // Data-phase slot control: size is no longer needed once on the data bus.
    typedef struct packed {
        logic valid;
        logic write;
        logic lerr;
    } d_slot_t;

    // Widest legal HSIZE for a data bus of xlen bits.
    function automatic logic [2:0] max_hsize(input int xlen);
        case (xlen)
            8:       return HSIZE_B8;
            16:      return HSIZE_B16;
            32:      return HSIZE_B32;
            64:      return HSIZE_B64;
            128:     return HSIZE_B128;
            256:     return HSIZE_B256;
            512:     return HSIZE_B512;
            1024:    return HSIZE_B1024;
            default: return HSIZE_B8;
        endcase
    endfunction

endpackage

// File: rtl/peripheral_mpram_ahb4_align_check.sv
// Flags a request that cannot go on the bus: address not a multiple of the
// transfer size, or a size wider than the data bus.
module peripheral_mpram_ahb4_align_check
    import peripheral_mpram_ahb4_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [6:0] addr_lsb,
    input  logic [2:0] size,
    output logic       misaligned
);

    localparam logic [2:0] MAX_SIZE = max_hsize(XLEN);

    logic [6:0] lane_mask;

    // Low address bits that must be zero for this size, then the check itself.
    always_comb begin
        lane_mask  = 7'((8'd1 << size) - 8'd1);
        misaligned = (size > MAX_SIZE) | (|(addr_lsb & lane_mask));
    end

endmodule

// File: rtl/peripheral_mpram_ahb4_master.sv
// Per-core AHB-Lite master: valid/ready requests in, in-order response
// pulses out, single NONSEQ transfers pipelined through an address slot (A)
// and a data slot (D).
//
// Handshake: a request transfers on a rising HCLK edge where
// req_valid & req_ready; req_valid/fields must stay stable until then.
// rsp_valid is a one-cycle pulse with no backpressure.
module peripheral_mpram_ahb4_master
    import peripheral_mpram_ahb4_pkg::*;
#(
    parameter int         XLEN      = 64,
    parameter int         PLEN      = 64,
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic            HCLK,
    input  logic            HRESET,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [PLEN-1:0] req_addr,
    input  logic [2:0]      req_size,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic            HSEL,
    output logic [PLEN-1:0] HADDR,
    output logic [XLEN-1:0] HWDATA,
    input  logic [XLEN-1:0] HRDATA,
    output logic            HWRITE,
    output logic [2:0]      HSIZE,
    output logic [2:0]      HBURST,
    output logic [3:0]      HPROT,
    output logic [1:0]      HTRANS,
    output logic            HMASTLOCK,
    input  logic            HREADYOUT,
    output logic            HREADY,
    input  logic            HRESP,
    output fsm_state_t      dbg_state
);

    fsm_state_t      state_q, state_d;
    a_slot_t         a_q, a_d;
    d_slot_t         d_q, d_d;
    logic [PLEN-1:0] a_addr_q;
    logic [XLEN-1:0] a_wdata_q, d_wdata_q;
    logic [1:0]      htrans_q, htrans_d;
    logic            rsp_valid_q, rsp_err_q;
    logic [XLEN-1:0] rsp_rdata_q;
    logic            new_mis, accept, shift_run, shift_err, retire;

    peripheral_mpram_ahb4_align_check #(.XLEN(XLEN)) u_align (
        .addr_lsb   (req_addr[6:0]),
        .size       (req_size),
        .misaligned (new_mis)
    );

    assign accept = req_valid & req_ready;
    assign retire = shift_run | shift_err;

    // FSM state register.
    always_ff @(posedge HCLK) begin
        if (HRESET) state_q <= ST_RUN;
        else        state_q <= state_d;
    end

    // FSM next state: a stalled ERROR on the data phase starts the flush.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (d_q.valid && HRESP && !HREADYOUT) state_d = ST_ERR1;
            ST_ERR1: state_d = ST_ERR2;
            ST_ERR2: state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    // FSM outputs: RUN advances on HREADYOUT, error states advance every cycle.
    always_comb begin
        req_ready = 1'b0;
        shift_run = 1'b0;
        shift_err = 1'b0;
        case (state_q)
            ST_RUN: begin
                req_ready = HREADYOUT;
                shift_run = HREADYOUT;
            end
            ST_ERR1, ST_ERR2: shift_err = 1'b1;
            default: ;
        endcase
    end

    // Next slot contents; during the flush A empties and its entry becomes a cancelled D.
    always_comb begin
        a_d = a_q;
        if (shift_run) begin
            if (accept) a_d = '{valid: 1'b1, write: req_write, size: req_size, lerr: new_mis};
            else        a_d.valid = 1'b0;
        end else if (shift_err) begin
            a_d.valid = 1'b0;
        end
        d_d = '{valid: a_q.valid, write: a_q.write, lerr: a_q.lerr | shift_err};
        htrans_d = (a_d.valid && !a_d.lerr && state_d == ST_RUN) ? HTRANS_NONSEQ : HTRANS_IDLE;
    end

    // Pipeline slots, bus address/data registers and the response pulse.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            a_q         <= '0;
            d_q         <= '0;
            a_addr_q    <= '0;
            a_wdata_q   <= '0;
            d_wdata_q   <= '0;
            htrans_q    <= HTRANS_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            a_q      <= a_d;
            htrans_q <= htrans_d;
            if (shift_run && accept) begin
                a_addr_q  <= req_addr;
                a_wdata_q <= req_wdata;
            end
            if (retire) begin
                d_q       <= d_d;
                d_wdata_q <= a_wdata_q;
            end
            rsp_valid_q <= retire & d_q.valid;
            rsp_err_q   <= retire & d_q.valid & (shift_err | d_q.lerr | HRESP);
            rsp_rdata_q <= (shift_run && d_q.valid && !d_q.write && !d_q.lerr && !HRESP)
                           ? HRDATA : '0;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign HTRANS    = htrans_q;
    assign HSEL      = (htrans_q != HTRANS_IDLE);
    assign HADDR     = a_addr_q;
    assign HWRITE    = a_q.write;
    assign HSIZE     = a_q.size;
    assign HWDATA    = d_wdata_q;
    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = HPROT_VAL;
    assign HMASTLOCK = 1'b0;
    assign HREADY    = HREADYOUT;
    assign dbg_state = state_q;

endmodule
